// File: rtl/md4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : md4_pkg
// Description : Shared types, round constants, schedule tables and step
//               functions for the iterative MD4 compression core.
// Revision    : 1.0 - initial release
// ============================================================================
package md4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0]  c_k_r1       = 32'h0000_0000;
    localparam logic [31:0]  c_k_r2       = 32'h5A82_7999;
    localparam logic [31:0]  c_k_r3       = 32'h6ED9_EBA1;
    localparam logic [127:0] c_default_iv = 128'h10325476_98badcfe_efcdab89_67452301;

    localparam logic [3:0] c_word_idx [0:47] = '{
        4'd0, 4'd1, 4'd2,  4'd3,  4'd4, 4'd5,  4'd6, 4'd7,
        4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
        4'd0, 4'd4, 4'd8,  4'd12, 4'd1, 4'd5,  4'd9, 4'd13,
        4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7,  4'd11, 4'd15,
        4'd0, 4'd8, 4'd4,  4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
        4'd1, 4'd9, 4'd5,  4'd13, 4'd3, 4'd11, 4'd7, 4'd15
    };

    localparam logic [4:0] c_shift [0:47] = '{
        5'd3, 5'd7, 5'd11, 5'd19, 5'd3, 5'd7, 5'd11, 5'd19,
        5'd3, 5'd7, 5'd11, 5'd19, 5'd3, 5'd7, 5'd11, 5'd19,
        5'd3, 5'd5, 5'd9,  5'd13, 5'd3, 5'd5, 5'd9,  5'd13,
        5'd3, 5'd5, 5'd9,  5'd13, 5'd3, 5'd5, 5'd9,  5'd13,
        5'd3, 5'd9, 5'd11, 5'd15, 5'd3, 5'd9, 5'd11, 5'd15,
        5'd3, 5'd9, 5'd11, 5'd15, 5'd3, 5'd9, 5'd11, 5'd15
    };

    function automatic logic [31:0] f_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
        return (x & y) | (~x & z);
    endfunction

    function automatic logic [31:0] g_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    function automatic logic [31:0] h_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] z);
        return x ^ y ^ z;
    endfunction

    // Only ever called with a constant amount, so it reduces to wiring.
    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

endpackage
`default_nettype wire

// File: rtl/md4_iter_core_if.sv
`default_nettype none
// ============================================================================
// Module      : md4_iter_core_if
// Description : Block-in / digest-out valid-ready bundle for md4_iter_core.
// Revision    : 1.0 - initial release
// ============================================================================
interface md4_iter_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_digest;

    modport master (
        output in_valid, in_block, in_first, out_ready,
        input  in_ready, out_valid, out_digest
    );

    modport slave (
        input  in_valid, in_block, in_first, out_ready,
        output in_ready, out_valid, out_digest
    );
endinterface
`default_nettype wire

// File: rtl/md4_step.sv
`default_nettype none
// ============================================================================
// Module      : md4_step
// Description : One combinational MD4 step; round function, constant and
//               rotation are selected from the step index.
// Revision    : 1.0 - initial release
// ============================================================================
module md4_step
    import md4_pkg::*;
(
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic [31:0] i_c,
    input  wire logic [31:0] i_d,
    input  wire logic [31:0] i_x,
    input  wire logic [5:0]  i_step,
    output logic [31:0]      o_new
);
    logic [31:0] w_fn;
    logic [31:0] w_k;
    logic [31:0] w_sum;
    logic [4:0]  w_shift;

    always_comb begin
        w_fn = f_fn(i_b, i_c, i_d);
        w_k  = c_k_r1;
        if (i_step >= 6'd32) begin
            w_fn = h_fn(i_b, i_c, i_d);
            w_k  = c_k_r3;
        end else if (i_step >= 6'd16) begin
            w_fn = g_fn(i_b, i_c, i_d);
            w_k  = c_k_r2;
        end
        w_sum   = i_a + w_fn + i_x + w_k;
        w_shift = c_shift[i_step];
        // A mux over fixed rotations rather than a barrel shifter.
        o_new = w_sum;
        case (w_shift)
            5'd3:    o_new = rotl32(w_sum, 5'd3);
            5'd5:    o_new = rotl32(w_sum, 5'd5);
            5'd7:    o_new = rotl32(w_sum, 5'd7);
            5'd9:    o_new = rotl32(w_sum, 5'd9);
            5'd11:   o_new = rotl32(w_sum, 5'd11);
            5'd13:   o_new = rotl32(w_sum, 5'd13);
            5'd15:   o_new = rotl32(w_sum, 5'd15);
            5'd19:   o_new = rotl32(w_sum, 5'd19);
            default: o_new = w_sum;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/md4_iter_core.sv
`default_nettype none
// ============================================================================
// Module      : md4_iter_core
// Description : Iterative multi-block MD4 compression, STEPS_PER_CYCLE steps
//               per clock. Define MD4_CHAIN_EN to keep the chaining value
//               across blocks; otherwise every block starts from IV.
// Revision    : 1.0 - initial release
// ============================================================================
module md4_iter_core
    import md4_pkg::*;
#(
    parameter int unsigned  STEPS_PER_CYCLE = 1,
    parameter logic [127:0] IV              = c_default_iv
) (
    input  wire logic      clk,
    input  wire logic      rst,
    md4_iter_core_if.slave bus
);
    localparam logic [5:0] c_steps    = 6'(STEPS_PER_CYCLE);
    localparam logic [5:0] c_last_cnt = 6'(48 - STEPS_PER_CYCLE);
    localparam int         c_tail     = int'(STEPS_PER_CYCLE) - 1;

    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4) begin : g_bad_steps
        $error("md4_iter_core: STEPS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t       r_state;
    state_t       w_next_state;
    logic         w_accept;
    logic         w_finish;
    logic         w_in_ready;
    logic         w_out_valid;
    logic [5:0]   r_cnt;
    logic [511:0] r_block;
    logic [31:0]  r_wa, r_wb, r_wc, r_wd;
    logic [31:0]  w_fa, w_fb, w_fc, w_fd;
    logic [127:0] r_digest;
    logic [127:0] w_digest;
    logic [127:0] w_start_cv;
    logic [127:0] w_chain_cv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_last_cnt) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_digest = r_digest;

    // Each stage hands (d, new, b, c) on as the next stage's (a, b, c, d).
    for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
        logic [31:0] w_ai, w_bi, w_ci, w_di, w_x, w_new;
        logic [5:0]  w_idx;

        if (j == 0) begin : g_head
            assign w_ai = r_wa;
            assign w_bi = r_wb;
            assign w_ci = r_wc;
            assign w_di = r_wd;
        end else begin : g_link
            assign w_ai = g_step[j-1].w_di;
            assign w_bi = g_step[j-1].w_new;
            assign w_ci = g_step[j-1].w_bi;
            assign w_di = g_step[j-1].w_ci;
        end

        assign w_idx = r_cnt + 6'(j);
        assign w_x   = r_block[32*c_word_idx[w_idx] +: 32];

        md4_step u_step (
            .i_a    (w_ai),
            .i_b    (w_bi),
            .i_c    (w_ci),
            .i_d    (w_di),
            .i_x    (w_x),
            .i_step (w_idx),
            .o_new  (w_new)
        );
    end

    assign w_fa = g_step[c_tail].w_di;
    assign w_fb = g_step[c_tail].w_new;
    assign w_fc = g_step[c_tail].w_bi;
    assign w_fd = g_step[c_tail].w_ci;

    assign w_digest = {w_fd + w_chain_cv[127:96], w_fc + w_chain_cv[95:64],
                       w_fb + w_chain_cv[63:32],  w_fa + w_chain_cv[31:0]};

`ifdef MD4_CHAIN_EN
    logic [127:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_chain <= IV;
        else if (w_finish) r_chain <= w_digest;
    end

    assign w_start_cv = bus.in_first ? IV : r_chain;
    assign w_chain_cv = r_chain;
`else
    logic w_unused_first;
    assign w_unused_first = bus.in_first;
    assign w_start_cv     = IV;
    assign w_chain_cv     = IV;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_block  <= '0;
            r_wa     <= '0;
            r_wb     <= '0;
            r_wc     <= '0;
            r_wd     <= '0;
            r_digest <= '0;
        end else if (w_accept) begin
            r_cnt                    <= '0;
            r_block                  <= bus.in_block;
            {r_wd, r_wc, r_wb, r_wa} <= w_start_cv;
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt + c_steps;
            r_wa  <= w_fa;
            r_wb  <= w_fb;
            r_wc  <= w_fc;
            r_wd  <= w_fd;
            if (w_finish) r_digest <= w_digest;
        end
    end
endmodule
`default_nettype wire
